fetch_stage: RTL and testbench

//  Instruction fetch stage of MicroEV20; sits directly upstream of prediction_control.
//  - Owns the PC and drives the synchronous program ROM (1-cycle read latency).
//  - Presents each fetched instruction and its PC to prediction_control.
//  - Consumes prediction_control's result: redirects on unconditional jumps.
//  - On conditional branches, holds fetch until execute resolves the branch.

---
 rtl/microev_pkg.sv | 6 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_sat.sv | 16 +
 rtl/fetch_stage.sv | 100 ++++++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microev_pkg.sv
// microev_pkg: shared MicroEV20 encodings used by the fetch stage
package microev_pkg;
   typedef enum logic {S_RUN = 1'b0, S_WAIT_BR = 1'b1} state_e;
   localparam logic [2:0]  OP_JMP    = 3'b100;
   localparam logic [13:0] NOP_INSTR = 14'h0000;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch stage links to the ROM, prediction_control and execute
interface fetch_stage_if #(
   parameter int PC_W  = 11,
   parameter int I_W   = 14,
   parameter int CNT_W = 16
);
   logic             stall_i;
   logic [PC_W-1:0]  imem_addr;
   logic [I_W-1:0]   imem_data;
   logic [I_W-1:0]   ir_o;
   logic [PC_W-1:0]  pc_o;
   logic             ir_valid_o;
   logic             pred_hold;
   logic [PC_W-1:0]  pred_next;
   logic             br_valid;
   logic             br_taken;
   logic [PC_W-1:0]  br_target;
   logic [CNT_W-1:0] bubble_cnt;
   modport master (
      input  stall_i, imem_data, pred_hold, pred_next, br_valid, br_taken, br_target,
      output imem_addr, ir_o, pc_o, ir_valid_o, bubble_cnt
   );
   modport slave (
      output stall_i, imem_data, pred_hold, pred_next, br_valid, br_taken, br_target,
      input  imem_addr, ir_o, pc_o, ir_valid_o, bubble_cnt
   );
endinterface

// File: rtl/fetch_stage_sat.sv
// fetch_stage_sat: saturating up-counter with synchronous active-low clear
module fetch_stage_sat #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;
   // step by one unless already pinned at all-ones
   always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   // count register
   always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MicroEV20 PC owner, ROM driver and branch/jump redirect control
module fetch_stage
   import microev_pkg::*;
#(
   parameter int              PC_W     = 11,
   parameter int              I_W      = 14,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 16
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);
   state_e          state_q, state_d;
   logic [PC_W-1:0] fpc_q, fpc_d, pc_q, pc_d, ret_q, ret_d, br_tgt_q, br_tgt_d;
   logic            vld_q, vld_d, br_pend_q, br_pend_d;
   logic            is_jump, br_go;
   logic [PC_W-1:0] br_now, br_addr;

   assign bus.imem_addr  = bus.stall_i ? pc_q : fpc_q;
   assign bus.ir_o       = vld_q ? bus.imem_data : NOP_INSTR;
   assign bus.pc_o       = pc_q;
   assign bus.ir_valid_o = vld_q;
   assign is_jump        = vld_q && bus.ir_o[I_W-1 -: 3] == OP_JMP;
   assign br_now         = bus.br_taken ? bus.br_target : ret_q;
   assign br_go          = bus.br_valid || br_pend_q;
   assign br_addr        = br_pend_q ? br_tgt_q : br_now;

   // state and datapath registers; reset drops any pending redirect
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         fpc_q     <= RESET_PC;
         pc_q      <= '0;
         vld_q     <= 1'b0;
         ret_q     <= '0;
         br_pend_q <= 1'b0;
         br_tgt_q  <= '0;
      end else begin
         state_q   <= state_d;
         fpc_q     <= fpc_d;
         pc_q      <= pc_d;
         vld_q     <= vld_d;
         ret_q     <= ret_d;
         br_pend_q <= br_pend_d;
         br_tgt_q  <= br_tgt_d;
      end
   end

   // next state: enter WAIT_BR on a predicted conditional branch, leave on resolution
   always_comb begin
      state_d = bus.stall_i ? state_q
              : state_q == S_RUN ? ((!is_jump && vld_q && bus.pred_hold) ? S_WAIT_BR : S_RUN)
              : (br_go ? S_RUN : S_WAIT_BR);
   end

   // datapath updates: stall holds (latching late resolutions), jump squashes, else advance
   always_comb begin
      fpc_d     = fpc_q;
      pc_d      = pc_q;
      vld_d     = vld_q;
      ret_d     = ret_q;
      br_pend_d = br_pend_q;
      br_tgt_d  = br_tgt_q;
      if (bus.stall_i) begin
         if (state_q == S_WAIT_BR && bus.br_valid && !br_pend_q) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_now;
         end
      end else if (state_q == S_RUN) begin
         if (is_jump) begin
            fpc_d = bus.pred_next;
            vld_d = 1'b0;
         end else if (vld_q && bus.pred_hold) begin
            ret_d = pc_q + 1'b1;
            vld_d = 1'b0;
         end else begin
            pc_d  = fpc_q;
            fpc_d = fpc_q + 1'b1;
            vld_d = 1'b1;
         end
      end else begin
         vld_d = 1'b0;
         if (br_go) begin
            fpc_d     = br_addr;
            br_pend_d = 1'b0;
         end
      end
   end

   fetch_stage_sat #(.W(CNT_W)) u_bubble (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (!bus.stall_i && !vld_q),
      .cnt_o (bus.bubble_cnt)
   );

   a_br_in_run: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.br_valid && state_q == S_RUN));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus pc scoreboard for the fetch stage
module tb_fetch_stage;
   import microev_pkg::*;
   localparam int PC_W = 11, I_W = 14, CNT_W = 8;

   typedef struct {
      logic             stall;
      logic [PC_W-1:0]  pc;
      logic             vld;
      logic [PC_W-1:0]  addr;
      logic [CNT_W-1:0] bub;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if #(.PC_W(PC_W), .I_W(I_W), .CNT_W(CNT_W)) bus ();
   fetch_stage #(.PC_W(PC_W), .I_W(I_W), .RESET_PC(11'h000), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [I_W-1:0]   rom [2**PC_W];
   logic [PC_W-1:0]  exp_q [$];
   logic [CNT_W-1:0] bub_m;
   bit               mon_en = 1'b0;
   int               total = 0, bad = 0;
   vec_t             tv [11];

   // synchronous ROM and a minimal prediction_control: 100 = jump, 101 = conditional branch
   always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
   assign bus.pred_hold = bus.ir_valid_o && bus.ir_o[13:11] == 3'b101;
   assign bus.pred_next = (bus.ir_o[13:11] == OP_JMP) ? bus.ir_o[10:0] : bus.pc_o;

   // reference bubble count: non-stalled cycles without a valid instruction
   always @(posedge clk)
      if (!rst_n) bub_m <= '0;
      else if (!bus.stall_i && !bus.ir_valid_o && bub_m != '1) bub_m <= bub_m + 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // scoreboard: every issued instruction must be the next expected pc with its ROM word
   always @(negedge clk)
      if (mon_en && rst_n && !bus.stall_i && bus.ir_valid_o) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got pc %0h want none", bus.pc_o);
         end else begin
            logic [PC_W-1:0] p;
            p = exp_q.pop_front();
            chk("sb_pc", 32'(bus.pc_o), 32'(p));
            chk("sb_ir", 32'(bus.ir_o), 32'(rom[p]));
         end
      end

   function automatic vec_t mk(input logic s, input int pc, input logic v, input int a, input int b);
      mk.stall = s;
      mk.pc    = PC_W'(pc);
      mk.vld   = v;
      mk.addr  = PC_W'(a);
      mk.bub   = CNT_W'(b);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rom();
      for (int i = 0; i < 2**PC_W; i++) rom[i] = {3'b010, PC_W'(i)};
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mon_en = 1'b0;
      bus.stall_i = 1'b0;
      bus.br_valid = 1'b0;
      bus.br_taken = 1'b0;
      bus.br_target = '0;
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic push_seq(input int from, input int to);
      for (int i = from; i <= to; i++) exp_q.push_back(PC_W'(i));
   endtask

   task automatic wait_pc(input int p, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.ir_valid_o && bus.pc_o == PC_W'(p)) && n < budget);
      chk("wait_pc", 32'(bus.pc_o), 32'(p));
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("sb_left", 32'(exp_q.size()), 32'd0);
      chk("bub_model", 32'(bus.bubble_cnt), 32'(bub_m));
      mon_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      tv[0]  = mk(0, 0, 0, 0, 0);
      tv[1]  = mk(0, 0, 1, 1, 1);
      tv[2]  = mk(0, 1, 1, 2, 1);
      tv[3]  = mk(0, 2, 1, 3, 1);
      tv[4]  = mk(1, 3, 1, 3, 1);
      tv[5]  = mk(1, 3, 1, 3, 1);
      tv[6]  = mk(1, 3, 1, 3, 1);
      tv[7]  = mk(1, 3, 1, 3, 1);
      tv[8]  = mk(0, 3, 1, 4, 1);
      tv[9]  = mk(0, 4, 1, 5, 1);
      tv[10] = mk(0, 5, 1, 6, 1);

      // sequential walk from reset with a 4-cycle stall at pc 3
      load_rom();
      do_reset();
      push_seq(0, 5);
      mon_en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.stall_i = tv[i].stall;
         @(negedge clk);
         chk($sformatf("A%0d_pc", i), 32'(bus.pc_o), 32'(tv[i].pc));
         chk($sformatf("A%0d_vld", i), 32'(bus.ir_valid_o), 32'(tv[i].vld));
         chk($sformatf("A%0d_addr", i), 32'(bus.imem_addr), 32'(tv[i].addr));
         chk($sformatf("A%0d_bub", i), 32'(bus.bubble_cnt), 32'(tv[i].bub));
         chk($sformatf("A%0d_ir", i), 32'(bus.ir_o), tv[i].vld ? 32'(rom[tv[i].pc]) : 32'd0);
         step();
      end
      mon_en = 1'b0;
      chk("A_sb_left", 32'(exp_q.size()), 32'd0);

      // unconditional jump at 5 to 0x040; word 6 squashed
      load_rom();
      rom[5] = {3'b100, 11'h040};
      do_reset();
      push_seq(0, 5);
      push_seq(11'h040, 11'h042);
      mon_en = 1'b1;
      wait_pc(5, 20);
      step();
      @(negedge clk);
      chk("B_squash_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("B_squash_ir", 32'(bus.ir_o), 32'd0);
      step();
      @(negedge clk);
      chk("B_tgt_pc", 32'(bus.pc_o), 32'h040);
      chk("B_tgt_vld", 32'(bus.ir_valid_o), 32'd1);
      drain(20);

      // conditional branch at 8, resolved not-taken after 3 wait cycles
      load_rom();
      rom[8] = {3'b101, 11'h000};
      do_reset();
      push_seq(0, 10);
      mon_en = 1'b1;
      wait_pc(8, 30);
      step();
      @(negedge clk);
      chk("C_wait_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("C_wait_addr", 32'(bus.imem_addr), 32'd9);
      step();
      step();
      bus.br_valid = 1'b1;
      bus.br_taken = 1'b0;
      bus.br_target = 11'h100;
      step();
      bus.br_valid = 1'b0;
      @(negedge clk);
      chk("C_redir_vld", 32'(bus.ir_valid_o), 32'd0);
      step();
      @(negedge clk);
      chk("C_ret_pc", 32'(bus.pc_o), 32'd9);
      chk("C_ret_vld", 32'(bus.ir_valid_o), 32'd1);
      drain(20);

      // taken branch after a long wait that saturates the bubble counter
      do_reset();
      push_seq(0, 8);
      push_seq(11'h100, 11'h101);
      mon_en = 1'b1;
      wait_pc(8, 30);
      repeat (300) step();
      @(negedge clk);
      chk("C2_sat", 32'(bus.bubble_cnt), 32'hFF);
      bus.br_valid = 1'b1;
      bus.br_taken = 1'b1;
      bus.br_target = 11'h100;
      step();
      bus.br_valid = 1'b0;
      step();
      @(negedge clk);
      chk("C2_tgt_pc", 32'(bus.pc_o), 32'h100);
      chk("C2_tgt_vld", 32'(bus.ir_valid_o), 32'd1);
      drain(20);

      // resolution arriving while stalled in WAIT_BR is applied after the stall
      do_reset();
      push_seq(0, 8);
      push_seq(11'h100, 11'h101);
      mon_en = 1'b1;
      wait_pc(8, 30);
      step();
      step();
      bus.stall_i = 1'b1;
      step();
      bus.br_valid = 1'b1;
      bus.br_taken = 1'b1;
      bus.br_target = 11'h100;
      step();
      bus.br_valid = 1'b0;
      @(negedge clk);
      chk("D_stall_pc", 32'(bus.pc_o), 32'd8);
      chk("D_stall_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("D_stall_addr", 32'(bus.imem_addr), 32'd8);
      step();
      bus.stall_i = 1'b0;
      @(negedge clk);
      chk("D_held_addr", 32'(bus.imem_addr), 32'd9);
      step();
      @(negedge clk);
      chk("D_redir_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("D_redir_addr", 32'(bus.imem_addr), 32'h100);
      step();
      @(negedge clk);
      chk("D_tgt_pc", 32'(bus.pc_o), 32'h100);
      chk("D_tgt_vld", 32'(bus.ir_valid_o), 32'd1);
      drain(20);

      // pc wraps from 0x7FF to 0x000
      load_rom();
      rom[2] = {3'b100, 11'h7FD};
      do_reset();
      push_seq(0, 2);
      push_seq(11'h7FD, 11'h7FF);
      push_seq(0, 1);
      mon_en = 1'b1;
      wait_pc(11'h7FF, 30);
      step();
      @(negedge clk);
      chk("E_wrap_pc", 32'(bus.pc_o), 32'd0);
      chk("E_wrap_vld", 32'(bus.ir_valid_o), 32'd1);
      drain(20);

      // reset in WAIT_BR with a latched redirect pending discards it
      load_rom();
      rom[8] = {3'b101, 11'h000};
      do_reset();
      push_seq(0, 8);
      mon_en = 1'b1;
      wait_pc(8, 30);
      step();
      bus.stall_i = 1'b1;
      bus.br_valid = 1'b1;
      bus.br_taken = 1'b1;
      bus.br_target = 11'h100;
      step();
      bus.br_valid = 1'b0;
      chk("F_sb_left", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      bus.stall_i = 1'b0;
      @(negedge clk);
      chk("F_rst_pc", 32'(bus.pc_o), 32'd0);
      chk("F_rst_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("F_rst_bub", 32'(bus.bubble_cnt), 32'd0);
      chk("F_rst_addr", 32'(bus.imem_addr), 32'd0);
      push_seq(0, 8);
      mon_en = 1'b1;
      step();
      @(negedge clk);
      chk("F_first_pc", 32'(bus.pc_o), 32'd0);
      chk("F_first_vld", 32'(bus.ir_valid_o), 32'd1);
      chk("F_first_bub", 32'(bus.bubble_cnt), 32'd1);
      wait_pc(8, 30);
      step();
      step();
      @(negedge clk);
      chk("F_wait_vld", 32'(bus.ir_valid_o), 32'd0);
      chk("F_wait_addr", 32'(bus.imem_addr), 32'd9);
      bus.br_valid = 1'b1;
      bus.br_taken = 1'b0;
      step();
      bus.br_valid = 1'b0;
      push_seq(9, 10);
      drain(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
